// File: rtl/upscale_line_scheduler.sv
// Vertical-upscale line scheduler: ping-pong input bank tracking plus SCALE output-line commands per input line.
// Optional: define UNDERRUN_CNT_EN to add the underrun_cnt[15:0] starvation counter output.
module upscale_line_scheduler #(
  parameter int SCALE    = 2,
  parameter int IN_LINES = 360,
  parameter int OUT_W    = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_start,
  input  logic             in_line_done,
  output logic             wr_bank,
  output logic             wr_allow,
  output logic             cmd_valid,
  input  logic             cmd_ready,
  output logic             cmd_bank,
  output logic [1:0]       cmd_phase,
  output logic [OUT_W-1:0] cmd_out_line,
  output logic             cmd_last,
  input  logic             proc_done,
  output logic             busy,
  output logic             frame_done,
  output logic             ovf
`ifdef UNDERRUN_CNT_EN
  ,output logic [15:0]     underrun_cnt
`endif
);

  localparam int LW = $clog2(IN_LINES + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_LINE, S_ISSUE, S_WAIT_DONE} state_t;

  state_t        r_state;
  logic [1:0]    r_full;
  logic          r_wr_bank;
  logic          r_rd_bank;
  logic [LW-1:0] r_in_line;
  logic [LW-1:0] r_wr_cnt;
  logic [1:0]    r_phase;
  logic          r_frame_done;
  logic          r_ovf;

  logic          w_wr_allow;
  logic          w_wr_fire;
  logic          w_last_phase;
  logic          w_last_line;
  logic          w_release;
  logic [1:0]    w_set_mask;
  logic [1:0]    w_clr_mask;

  assign w_wr_allow   = !r_full[r_wr_bank] && (r_wr_cnt < LW'(IN_LINES)) && (r_state != S_IDLE);
  assign w_wr_fire    = in_line_done && w_wr_allow;
  assign w_last_phase = (r_phase == 2'(SCALE - 1));
  assign w_last_line  = (r_in_line == LW'(IN_LINES - 1));
  assign w_release    = (r_state == S_WAIT_DONE) && proc_done && w_last_phase;
  // The writer only fills an empty bank and release only frees the full read bank,
  // so a same-cycle set and clear always target different bits.
  assign w_set_mask   = w_wr_fire ? (2'b01 << r_wr_bank) : 2'b00;
  assign w_clr_mask   = w_release ? (2'b01 << r_rd_bank) : 2'b00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_full       <= 2'b00;
      r_wr_bank    <= 1'b0;
      r_rd_bank    <= 1'b0;
      r_in_line    <= '0;
      r_wr_cnt     <= '0;
      r_phase      <= 2'd0;
      r_frame_done <= 1'b0;
      r_ovf        <= 1'b0;
    end else if (frame_start) begin
      r_state      <= S_WAIT_LINE;
      r_full       <= 2'b00;
      r_wr_bank    <= 1'b0;
      r_rd_bank    <= 1'b0;
      r_in_line    <= '0;
      r_wr_cnt     <= '0;
      r_phase      <= 2'd0;
      r_frame_done <= 1'b0;
      r_ovf        <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      r_full       <= (r_full | w_set_mask) & ~w_clr_mask;
      if (w_wr_fire) begin
        r_wr_bank <= ~r_wr_bank;
        r_wr_cnt  <= r_wr_cnt + LW'(1);
      end
      if (in_line_done && !w_wr_allow) r_ovf <= 1'b1;
      case (r_state)
        S_IDLE: ;
        S_WAIT_LINE: if (r_full[r_rd_bank]) r_state <= S_ISSUE;
        S_ISSUE:     if (cmd_ready) r_state <= S_WAIT_DONE;
        S_WAIT_DONE: begin
          if (proc_done) begin
            if (!w_last_phase) begin
              r_phase <= r_phase + 2'd1;
              r_state <= S_ISSUE;
            end else begin
              r_phase   <= 2'd0;
              r_rd_bank <= ~r_rd_bank;
              r_in_line <= r_in_line + LW'(1);
              if (w_last_line) begin
                r_state      <= S_IDLE;
                r_frame_done <= 1'b1;
              end else begin
                r_state <= S_WAIT_LINE;
              end
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef UNDERRUN_CNT_EN
  logic [15:0] r_underrun_cnt;

  // Starvation: process side waiting for a line after at least one line was consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_underrun_cnt <= 16'd0;
    else if (frame_start)
      r_underrun_cnt <= 16'd0;
    else if (r_state == S_WAIT_LINE && r_in_line != '0 && r_underrun_cnt != 16'hFFFF)
      r_underrun_cnt <= r_underrun_cnt + 16'd1;
  end

  assign underrun_cnt = r_underrun_cnt;
`endif

  assign wr_bank      = r_wr_bank;
  assign wr_allow     = w_wr_allow;
  assign cmd_valid    = (r_state == S_ISSUE);
  assign cmd_bank     = r_rd_bank;
  assign cmd_phase    = r_phase;
  assign cmd_out_line = OUT_W'(r_in_line) * OUT_W'(SCALE) + OUT_W'(r_phase);
  // Qualified by valid so a 1-line, SCALE=1 config still idles with cmd_last low.
  assign cmd_last     = cmd_valid && w_last_line && w_last_phase;
  assign busy         = (r_state != S_IDLE);
  assign frame_done   = r_frame_done;
  assign ovf          = r_ovf;

endmodule

// File: tb/tb_upscale_line_scheduler.sv
// Directed bench for upscale_line_scheduler at SCALE=2, IN_LINES=4, OUT_W=12.
module tb_upscale_line_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_start = 1'b0;
  logic        in_line_done = 1'b0;
  logic        wr_bank, wr_allow, cmd_valid;
  logic        cmd_ready = 1'b1;
  logic        cmd_bank;
  logic [1:0]  cmd_phase;
  logic [11:0] cmd_out_line;
  logic        cmd_last;
  logic        proc_done = 1'b0;
  logic        busy, frame_done, ovf;
`ifdef UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt;
`endif

  int n_chk = 0;
  int n_err = 0;
  int fd_cnt = 0;

  upscale_line_scheduler #(.SCALE(2), .IN_LINES(4), .OUT_W(12)) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .in_line_done(in_line_done),
    .wr_bank(wr_bank), .wr_allow(wr_allow), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_bank(cmd_bank), .cmd_phase(cmd_phase), .cmd_out_line(cmd_out_line),
    .cmd_last(cmd_last), .proc_done(proc_done), .busy(busy), .frame_done(frame_done),
    .ovf(ovf)
`ifdef UNDERRUN_CNT_EN
    ,.underrun_cnt(underrun_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (frame_done) fd_cnt <= fd_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_fs();
    frame_start = 1'b1; tick(); frame_start = 1'b0;
  endtask

  task automatic pulse_line();
    in_line_done = 1'b1; tick(); in_line_done = 1'b0;
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!cmd_valid && n < 60) begin tick(); n++; end
    if (!cmd_valid) chk("cmd_valid_timeout", 32'd0, 32'd1);
  endtask

  // Check one command, accept it, return proc_done 3 cycles after the accept edge.
  task automatic do_cmd(input int line, input int bank, input int ph, input int last);
    wait_valid();
    chk($sformatf("out_line%0d", line), 32'(cmd_out_line), 32'(line));
    chk($sformatf("bank%0d", line), 32'(cmd_bank), 32'(bank));
    chk($sformatf("phase%0d", line), 32'(cmd_phase), 32'(ph));
    chk($sformatf("last%0d", line), 32'(cmd_last), 32'(last));
    cmd_ready = 1'b1;
    tick();
    chk($sformatf("accepted%0d", line), 32'(cmd_valid), 32'd0);
    tick(); tick();
    proc_done = 1'b1; tick(); proc_done = 1'b0;
  endtask

  initial begin
    // Reset values
    #12;
    chk("rst_wr_bank", 32'(wr_bank), 32'd0);
    chk("rst_wr_allow", 32'(wr_allow), 32'd0);
    chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    chk("rst_cmd_last", 32'(cmd_last), 32'd0);
    chk("rst_out_line", 32'(cmd_out_line), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;
    tick(); tick();

    // Full frame: 4 lines, 8 commands
    pulse_fs();
    chk("fs_busy", 32'(busy), 32'd1);
    chk("fs_wr_allow", 32'(wr_allow), 32'd1);
    for (int l = 0; l < 4; l++) begin
      pulse_line();
      if (l == 0) begin
        chk("lat_full_cycle", 32'(cmd_valid), 32'd0);
        tick();
        chk("lat_valid_cycle", 32'(cmd_valid), 32'd1);
      end
      do_cmd(2*l, l % 2, 0, 0);
      chk($sformatf("next_valid_l%0d", l), 32'(cmd_valid), 32'd1);
      do_cmd(2*l + 1, l % 2, 1, (l == 3) ? 1 : 0);
      if (l < 3) repeat (8) tick();
    end
    chk("frame_done_pulse", 32'(frame_done), 32'd1);
    chk("end_busy", 32'(busy), 32'd0);
    tick();
    chk("frame_done_drop", 32'(frame_done), 32'd0);
    chk("frame_done_count", 32'(fd_cnt), 32'd1);

    // Back-to-back lines with processing stalled, then overflow
    pulse_fs();
    cmd_ready = 1'b0;
    in_line_done = 1'b1; tick(); tick(); in_line_done = 1'b0;
    chk("b2b_wr_allow", 32'(wr_allow), 32'd0);
    chk("b2b_full", 32'(dut.r_full), 32'd3);
    chk("b2b_ovf_pre", 32'(ovf), 32'd0);
    pulse_line();
    chk("b2b_ovf", 32'(ovf), 32'd1);
    chk("b2b_wr_cnt", 32'(dut.r_wr_cnt), 32'd2);

    // cmd_ready withheld for 10 cycles in ISSUE
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("hold%0d", i), {27'd0, cmd_valid, cmd_bank, cmd_phase, cmd_last},
          {27'd0, 1'b1, 1'b0, 2'd0, 1'b0});
      chk($sformatf("hold_line%0d", i), 32'(cmd_out_line), 32'd0);
      tick();
    end
    cmd_ready = 1'b1;
    tick();
    chk("hold_accept", 32'(cmd_valid), 32'd0);

    // Same-cycle release of bank0 and write into bank1
    pulse_fs();
    pulse_line();
    do_cmd(0, 0, 0, 0);
    wait_valid();
    chk("same_out_line", 32'(cmd_out_line), 32'd1);
    tick(); tick(); tick();
    proc_done = 1'b1; in_line_done = 1'b1;
    tick();
    proc_done = 1'b0; in_line_done = 1'b0;
    chk("same_full", 32'(dut.r_full), 32'd2);
    chk("same_ovf", 32'(ovf), 32'd0);
    chk("same_wr_cnt", 32'(dut.r_wr_cnt), 32'd2);
    do_cmd(2, 1, 0, 0);
    do_cmd(3, 1, 1, 0);
    chk("same_full_clr", 32'(dut.r_full), 32'd0);

    // frame_start while waiting on proc_done for out_line 3
    pulse_fs();
    pulse_line();
    do_cmd(0, 0, 0, 0);
    do_cmd(1, 0, 1, 0);
    pulse_line();
    do_cmd(2, 1, 0, 0);
    wait_valid();
    chk("abort_out_line", 32'(cmd_out_line), 32'd3);
    tick();
    in_line_done = 1'b1; tick(); tick(); in_line_done = 1'b0;
    chk("abort_ovf_pre", 32'(ovf), 32'd1);
    frame_start = 1'b1; proc_done = 1'b1;
    tick();
    frame_start = 1'b0; proc_done = 1'b0;
    chk("abort_valid", 32'(cmd_valid), 32'd0);
    chk("abort_full", 32'(dut.r_full), 32'd0);
    chk("abort_ovf", 32'(ovf), 32'd0);
    chk("abort_state", 32'(dut.r_state), 32'd1);
    chk("abort_wr_bank", 32'(wr_bank), 32'd0);
    repeat (3) tick();
    chk("abort_idle_valid", 32'(cmd_valid), 32'd0);
    chk("abort_no_fd", 32'(fd_cnt), 32'd1);
    pulse_line();
    do_cmd(0, 0, 0, 0);

    // Asynchronous reset mid-frame
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_valid", 32'(cmd_valid), 32'd0);
    chk("arst_wr_allow", 32'(wr_allow), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

`ifdef UNDERRUN_CNT_EN
    pulse_fs();
    repeat (5) tick();
    chk("und_first_line", 32'(underrun_cnt), 32'd0);
    pulse_line();
    do_cmd(0, 0, 0, 0);
    do_cmd(1, 0, 1, 0);
    repeat (48) tick();
    pulse_line();
    tick();
    chk("und_valid", 32'(cmd_valid), 32'd1);
    chk("und_cnt", 32'(underrun_cnt), 32'd50);
    pulse_fs();
    chk("und_clr", 32'(underrun_cnt), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
